fetch_queue: RTL and testbench

- Decoupling FIFO between the fetch stage and decode.
- Buffers each fetched instruction with its PC and the branch-prediction metadata produced in fetch: predicted-taken bit and predicted target.
- Absorbs decode stalls without stalling PC generation.
- Supports a single-cycle flush on branch mispredict or redirect.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through FIFO between fetch and decode, carrying instruction, PC and prediction bits.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards an enqueue straight to the dequeue side when the queue is empty.
module fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [INSTR_WIDTH-1:0]   enq_instr_i,
  input  logic [ADDR_WIDTH-1:0]    enq_pc_i,
  input  logic                     enq_pred_taken_i,
  input  logic [ADDR_WIDTH-1:0]    enq_pred_trgt_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output logic [INSTR_WIDTH-1:0]   deq_instr_o,
  output logic [ADDR_WIDTH-1:0]    deq_pc_o,
  output logic                     deq_pred_taken_o,
  output logic [ADDR_WIDTH-1:0]    deq_pred_trgt_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("fetch_queue: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];
  logic                   taken_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  trgt_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic byp_vld;
  logic enq_fire;
  logic deq_fire;
  logic wr_en;
  logic rd_en;

  assign empty       = (count_q == '0);
  assign enq_ready_o = (count_q != FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_vld = empty & enq_valid_i & ~flush_i & ~rst;
`else
  assign byp_vld = 1'b0;
`endif

  assign deq_valid_o = ~empty | byp_vld;
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign deq_fire    = deq_valid_o & deq_ready_i;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en       = enq_fire & ~(byp_vld & deq_ready_i);
  assign rd_en       = deq_fire & ~empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rst || flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PTR_W'(1);
      if (rd_en) head_d = head_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Storage is only wiped by reset; flush just rewinds the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        taken_q[i] <= 1'b0;
        trgt_q[i]  <= '0;
      end
    end else if (wr_en && !flush_i) begin
      instr_q[tail_q] <= enq_instr_i;
      pc_q[tail_q]    <= enq_pc_i;
      taken_q[tail_q] <= enq_pred_taken_i;
      trgt_q[tail_q]  <= enq_pred_trgt_i;
    end
  end

  always_comb begin
    deq_instr_o      = '0;
    deq_pc_o         = '0;
    deq_pred_taken_o = 1'b0;
    deq_pred_trgt_o  = '0;
    if (byp_vld) begin
      deq_instr_o      = enq_instr_i;
      deq_pc_o         = enq_pc_i;
      deq_pred_taken_o = enq_pred_taken_i;
      deq_pred_trgt_o  = enq_pred_trgt_i;
    end else if (!empty) begin
      deq_instr_o      = instr_q[head_q];
      deq_pc_o         = pc_q[head_q];
      deq_pred_taken_o = taken_q[head_q];
      deq_pred_trgt_o  = trgt_q[head_q];
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [31:0] enq_instr_i;
  logic [31:0] enq_pc_i;
  logic        enq_pred_taken_i;
  logic [31:0] enq_pred_trgt_i;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [31:0] deq_instr_o;
  logic [31:0] deq_pc_o;
  logic        deq_pred_taken_o;
  logic [31:0] deq_pred_trgt_o;
  logic [2:0]  count_o;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] trgt;
  } entry_t;

  entry_t sb[$];
  entry_t mon_e;
  int vectors = 0;
  int miscompares = 0;

  fetch_queue #(.INSTR_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_instr_i(enq_instr_i), .enq_pc_i(enq_pc_i),
    .enq_pred_taken_i(enq_pred_taken_i), .enq_pred_trgt_i(enq_pred_trgt_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_instr_o(deq_instr_o), .deq_pc_o(deq_pc_o),
    .deq_pred_taken_o(deq_pred_taken_o), .deq_pred_trgt_o(deq_pred_trgt_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an enqueue; when the caller knows it will be accepted, its entry joins the scoreboard.
  task automatic set_enq(input logic [31:0] pc, input bit will_fire);
    entry_t e;
    e.pc    = pc;
    e.instr = 32'hC0DE_0000 ^ pc;
    e.taken = pc[2];
    e.trgt  = pc + 32'h0000_1000;
    enq_valid_i      = 1'b1;
    enq_pc_i         = e.pc;
    enq_instr_i      = e.instr;
    enq_pred_taken_i = e.taken;
    enq_pred_trgt_i  = e.trgt;
    if (will_fire) sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && !flush_i && deq_valid_o && deq_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_deq_pc", {32'h0, deq_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("deq_pc",    {32'h0, deq_pc_o},        {32'h0, mon_e.pc});
        chk("deq_instr", {32'h0, deq_instr_o},     {32'h0, mon_e.instr});
        chk("deq_taken", {63'h0, deq_pred_taken_o}, {63'h0, mon_e.taken});
        chk("deq_trgt",  {32'h0, deq_pred_trgt_o}, {32'h0, mon_e.trgt});
      end
    end
  end

  initial begin
    // Reset with random inputs
    rst              = 1'b1;
    flush_i          = 1'($urandom);
    enq_valid_i      = 1'($urandom);
    deq_ready_i      = 1'($urandom);
    enq_instr_i      = $urandom;
    enq_pc_i         = $urandom;
    enq_pred_taken_i = 1'($urandom);
    enq_pred_trgt_i  = $urandom;
    step();
    enq_valid_i = 1'b1;
    enq_pc_i    = $urandom;
    step();
    chk("rst_deq_valid", {63'h0, deq_valid_o}, 64'h0);
    chk("rst_enq_ready", {63'h0, enq_ready_o}, 64'h1);
    chk("rst_count",     {61'h0, count_o},     64'h0);
    chk("rst_deq_instr", {32'h0, deq_instr_o}, 64'h0);
    rst = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
    enq_instr_i = '0; enq_pc_i = '0; enq_pred_taken_i = 1'b0; enq_pred_trgt_i = '0;
    step();
    chk("idle_count", {61'h0, count_o}, 64'h0);

    // Fill to full, fifth enqueue refused
    for (int i = 0; i < 4; i++) begin
      set_enq(32'h100 + 32'(4 * i), 1'b1);
      step();
    end
    chk("full_count", {61'h0, count_o},     64'h4);
    chk("full_ready", {63'h0, enq_ready_o}, 64'h0);
    set_enq(32'h110, 1'b0);
    step();
    chk("full_count_hold", {61'h0, count_o}, 64'h4);

    // Full with both sides active: only the dequeue fires, enqueue follows next cycle
    set_enq(32'h110, 1'b1);
    deq_ready_i = 1'b1;
    step();
    chk("full_deq_count",  {61'h0, count_o},     64'h3);
    chk("full_deq_ready",  {63'h0, enq_ready_o}, 64'h1);
    step();
    chk("enq_after_full",  {61'h0, count_o},     64'h3);
    enq_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("drain_count", {61'h0, count_o},     64'h0);
    chk("drain_valid", {63'h0, deq_valid_o}, 64'h0);
    deq_ready_i = 1'b0;

    // Concurrent enq/deq at occupancy 2 across pointer wrap
    set_enq(32'h500, 1'b1); step();
    set_enq(32'h504, 1'b1); step();
    chk("conc_pre_count", {61'h0, count_o}, 64'h2);
    deq_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_enq(32'h508 + 32'(4 * i), 1'b1);
      step();
      chk("conc_count", {61'h0, count_o}, 64'h2);
    end
    enq_valid_i = 1'b0;
    step(); step();
    chk("conc_drain_count", {61'h0, count_o}, 64'h0);
    deq_ready_i = 1'b0;

    // Flush with concurrent enq and deq
    set_enq(32'h600, 1'b1); step();
    set_enq(32'h604, 1'b1); step();
    set_enq(32'h608, 1'b1); step();
    chk("pre_flush_count", {61'h0, count_o}, 64'h3);
    sb.delete();
    flush_i = 1'b1;
    set_enq(32'h200, 1'b0);
    deq_ready_i = 1'b1;
    step();
    flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
    #1;
    chk("flush_count", {61'h0, count_o},     64'h0);
    chk("flush_valid", {63'h0, deq_valid_o}, 64'h0);
    chk("flush_ready", {63'h0, enq_ready_o}, 64'h1);
    set_enq(32'h300, 1'b1);
    step();
    enq_valid_i = 1'b0;
    #1;
    chk("post_flush_valid", {63'h0, deq_valid_o}, 64'h1);
    chk("post_flush_pc",    {32'h0, deq_pc_o},    64'h300);
    chk("post_flush_count", {61'h0, count_o},     64'h1);
    deq_ready_i = 1'b1;
    step();
    deq_ready_i = 1'b0;
    chk("post_flush_drain", {61'h0, count_o}, 64'h0);

    // Empty-queue enqueue latency
    set_enq(32'h400, 1'b1);
    deq_ready_i = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid_same", {63'h0, deq_valid_o}, 64'h1);
    chk("byp_pc_same",    {32'h0, deq_pc_o},    64'h400);
    step();
    enq_valid_i = 1'b0;
    #1;
    chk("byp_count", {61'h0, count_o},     64'h0);
    chk("byp_valid", {63'h0, deq_valid_o}, 64'h0);
`else
    chk("lat_valid_same", {63'h0, deq_valid_o}, 64'h0);
    step();
    enq_valid_i = 1'b0;
    #1;
    chk("lat_valid_next", {63'h0, deq_valid_o}, 64'h1);
    chk("lat_pc_next",    {32'h0, deq_pc_o},    64'h400);
    chk("lat_count_next", {61'h0, count_o},     64'h1);
    step();
    chk("lat_drain_count", {61'h0, count_o}, 64'h0);
`endif
    deq_ready_i = 1'b0;
    step(); step();
    chk("scoreboard_left", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
